// File: rtl/imem_arbiter_ctrl_if.sv
// Bus bundle between the instruction-memory arbiter and its clients:
// CPU fetch port, program-loader port and the byte-wide memory array port.
interface imem_arbiter_ctrl_if #(
  parameter int AW = 7
);
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_err;
  logic          load_req;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic          load_ack;
  logic          load_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;

  // Arbiter side
  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
    output fetch_valid, fetch_instr, fetch_err, load_ack, load_err,
           mem_addr, mem_we, mem_wdata, busy
  );

  // Client / memory side
  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
    input  fetch_valid, fetch_instr, fetch_err, load_ack, load_err,
           mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_arbiter_ctrl.sv
// Round-robin arbiter between a CPU fetch port and a program loader sharing
// a byte-wide instruction memory. Words are moved as four big-endian byte
// beats; bad addresses are answered immediately without touching memory.
module imem_arbiter_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input logic               clk,
  input logic               rst_n,
  imem_arbiter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          last_load_q, last_load_d;   // 1: loader got the last grant
  logic          op_load_q, op_load_d;       // 1: current transaction is a load
  logic          err_q, err_d;
  logic [31:0]   instr_q, instr_d;
  logic [AW-1:0] base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [23:0]   asm_q, asm_d;               // first three fetched bytes

  logic          grant_load;
  logic [31:0]   sel_addr;
  logic [AW-1:0] beat_addr;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a > 32'(DEPTH - 4));
  endfunction

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    grant_load = bus.load_req && (!bus.fetch_req || !last_load_q);
    sel_addr   = grant_load ? bus.load_addr : bus.fetch_addr;
    beat_addr  = base_q + AW'(beat_q);
  end

  // Next-state, datapath next values and bus outputs
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    last_load_d     = last_load_q;
    op_load_d       = op_load_q;
    err_d           = err_q;
    instr_d         = instr_q;
    base_d          = base_q;
    wdata_d         = wdata_q;
    asm_d           = asm_q;
    bus.mem_addr    = '0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = 8'h00;
    bus.fetch_valid = 1'b0;
    bus.fetch_err   = 1'b0;
    bus.load_ack    = 1'b0;
    bus.load_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fetch_req || bus.load_req) begin
          op_load_d   = grant_load;
          last_load_d = grant_load;
          base_d      = sel_addr[AW-1:0];
          wdata_d     = bus.load_data;
          beat_d      = 2'd0;
          err_d       = addr_bad(sel_addr);
          if (addr_bad(sel_addr)) begin
            state_d = RESP;
            if (!grant_load) instr_d = 32'h0;
          end else begin
            state_d = grant_load ? WR : RD;
          end
        end
      end
      RD: begin
        bus.mem_addr = beat_addr;
        beat_d       = beat_q + 2'd1;
        case (beat_q)
          2'd0:    asm_d[23:16] = bus.mem_rdata;
          2'd1:    asm_d[15:8]  = bus.mem_rdata;
          2'd2:    asm_d[7:0]   = bus.mem_rdata;
          default: begin
            instr_d = {asm_q, bus.mem_rdata};
            state_d = RESP;
          end
        endcase
      end
      WR: begin
        bus.mem_addr = beat_addr;
        bus.mem_we   = 1'b1;
        beat_d       = beat_q + 2'd1;
        case (beat_q)
          2'd0:    bus.mem_wdata = wdata_q[31:24];
          2'd1:    bus.mem_wdata = wdata_q[23:16];
          2'd2:    bus.mem_wdata = wdata_q[15:8];
          default: bus.mem_wdata = wdata_q[7:0];
        endcase
        if (beat_q == 2'd3) state_d = RESP;
      end
      RESP: begin
        bus.fetch_valid = !op_load_q;
        bus.fetch_err   = !op_load_q && err_q;
        bus.load_ack    = op_load_q;
        bus.load_err    = op_load_q && err_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the visible instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      last_load_q <= 1'b0;
      op_load_q   <= 1'b0;
      err_q       <= 1'b0;
      instr_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_load_q <= last_load_d;
      op_load_q   <= op_load_d;
      err_q       <= err_d;
      instr_q     <= instr_d;
    end
  end

  // Latched address/data and partial fetch word; only read while busy
  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    asm_q   <= asm_d;
  end

  assign bus.fetch_instr = instr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_imem_arbiter_ctrl.sv
// Randomized scoreboard bench for imem_arbiter_ctrl with a word-level
// reference model of the memory, the arbitration order and response timing.
module tb_imem_arbiter_ctrl;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  typedef struct {
    bit          is_load;
    bit          err;
    logic [31:0] instr;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   nvec  = 0;
  int   nerr  = 0;

  imem_arbiter_ctrl_if #(.AW(AW)) bus();
  imem_arbiter_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide memory array behind the arbiter
  logic [7:0] mem [0:DEPTH-1];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  // Reference model state
  logic [7:0]  refmem [0:DEPTH-1];
  logic [31:0] ref_instr     = 32'h0;
  bit          ref_last_load = 1'b0;
  exp_t        sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Word-level model of one transaction starting at cycle base_cyc
  task automatic predict(input bit is_load, input logic [31:0] a, input logic [31:0] d,
                         input int base_cyc, output exp_t e, output int lat);
    bit bad;
    bad       = (a % 4 != 0) || (a > DEPTH - 4);
    lat       = bad ? 1 : 5;
    e.is_load = is_load;
    e.err     = bad;
    e.due     = base_cyc + lat;
    if (is_load) begin
      if (!bad) for (int i = 0; i < 4; i++) refmem[a[AW-1:0] + AW'(i)] = d[31-8*i -: 8];
    end else begin
      ref_instr = bad ? 32'h0 : {refmem[a[AW-1:0]], refmem[a[AW-1:0] + 7'd1],
                                 refmem[a[AW-1:0] + 7'd2], refmem[a[AW-1:0] + 7'd3]};
    end
    e.instr       = ref_instr;
    ref_last_load = is_load;
  endtask

  task automatic drop(input bit is_load);
    if (is_load) begin
      bus.load_req  = 1'b0;
      bus.load_addr = $urandom();
      bus.load_data = $urandom();
    end else begin
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = $urandom();
    end
  endtask

  task automatic wait_resp(input bit is_load);
    int n = 0;
    while (!(is_load ? bus.load_ack : bus.fetch_valid)) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        nvec++;
        nerr++;
        $display("FAIL resp_timeout: no %s response within 40 cycles", is_load ? "load" : "fetch");
        break;
      end
    end
  endtask

  task automatic single(input bit is_load, input logic [31:0] a, input logic [31:0] d,
                        input bit drop_early);
    exp_t e;
    int   l;
    @(negedge clk);
    if (is_load) begin
      bus.load_req = 1'b1; bus.load_addr = a; bus.load_data = d;
    end else begin
      bus.fetch_req = 1'b1; bus.fetch_addr = a;
    end
    predict(is_load, a, d, cyc, e, l);
    sbq.push_back(e);
    if (drop_early && l == 5) begin
      @(negedge clk);
      drop(is_load);
    end
    wait_resp(is_load);
    drop(is_load);
  endtask

  task automatic tie(input logic [31:0] fa, input logic [31:0] la, input logic [31:0] ld);
    exp_t e1, e2;
    int   l1, l2;
    bit   first_load;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = fa;
    bus.load_req  = 1'b1; bus.load_addr  = la; bus.load_data = ld;
    first_load = !ref_last_load;
    if (first_load) predict(1'b1, la, ld, cyc, e1, l1);
    else            predict(1'b0, fa, 32'h0, cyc, e1, l1);
    if (first_load) predict(1'b0, fa, 32'h0, cyc + l1 + 1, e2, l2);
    else            predict(1'b1, la, ld, cyc + l1 + 1, e2, l2);
    sbq.push_back(e1);
    sbq.push_back(e2);
    wait_resp(first_load);
    drop(first_load);
    wait_resp(!first_load);
    drop(!first_load);
  endtask

  // Load to 0x10 cut by reset during its third write beat
  task automatic reset_mid_write(input logic [31:0] d);
    @(negedge clk);
    bus.load_req = 1'b1; bus.load_addr = 32'h10; bus.load_data = d;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    drop(1'b1);
    #1;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_ack", {31'h0, bus.load_ack}, 32'h0);
    chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_instr", bus.fetch_instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_byte10", {24'h0, mem[16]}, {24'h0, d[31:24]});
    chk("rst_byte11", {24'h0, mem[17]}, {24'h0, d[23:16]});
    chk("rst_byte12", {24'h0, mem[18]}, {24'h0, refmem[18]});
    chk("rst_byte13", {24'h0, mem[19]}, {24'h0, refmem[19]});
    refmem[16]    = d[31:24];
    refmem[17]    = d[23:16];
    ref_last_load = 1'b0;
    ref_instr     = 32'h0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 31)) << 2;
    else if (r == 7) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 8) return 32'($urandom_range(32, 63)) << 2;
    else             return $urandom();
  endfunction

  // Monitor: pops the scoreboard whenever a response is presented
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fetch_valid || bus.load_ack) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_resp: valid=%0b ack=%0b with empty scoreboard", bus.fetch_valid, bus.load_ack);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_kind", {30'h0, bus.load_ack, bus.fetch_valid}, {30'h0, e.is_load, !e.is_load});
          chk("resp_err", {31'h0, e.is_load ? bus.load_err : bus.fetch_err}, {31'h0, e.err});
          chk("resp_instr", bus.fetch_instr, e.instr);
          chk("resp_cycle", cyc, e.due);
          chk("resp_memport", {23'h0, bus.mem_we, 1'b0, bus.mem_addr}, 32'h0);
        end
      end
      if (!bus.busy) chk("idle_memport", {23'h0, bus.mem_we, 1'b0, bus.mem_addr}, 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
    bus.load_req  = 1'b0; bus.load_addr  = 32'h0; bus.load_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom());
      mem[i]    <= v;
      refmem[i]  = v;
    end
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_fvalid", {31'h0, bus.fetch_valid}, 32'h0);
    chk("reset_lack", {31'h0, bus.load_ack}, 32'h0);
    chk("reset_we", {31'h0, bus.mem_we}, 32'h0);
    chk("reset_maddr", {25'h0, bus.mem_addr}, 32'h0);
    chk("reset_instr", bus.fetch_instr, 32'h0);
    rst_n = 1'b1;

    // Tie from reset: loader first, then the fetch reads what was loaded
    tie(32'h0, 32'h0, 32'h20100000);
    chk("first_fetch_model", ref_instr, 32'h20100000);
    tie($urandom_range(0, 31) << 2, $urandom_range(0, 31) << 2, $urandom());
    single(1'b1, 32'h44, $urandom(), 1'b0);
    tie($urandom_range(0, 31) << 2, $urandom_range(0, 31) << 2, $urandom());

    single(1'b1, 32'h08, 32'h12345678, 1'b0);
    chk("byte08", {24'h0, mem[8]},  32'h12);
    chk("byte09", {24'h0, mem[9]},  32'h34);
    chk("byte0a", {24'h0, mem[10]}, 32'h56);
    chk("byte0b", {24'h0, mem[11]}, 32'h78);

    single(1'b0, 32'h06, 32'h0, 1'b0);
    single(1'b0, 32'h7C, 32'h0, 1'b0);
    single(1'b0, 32'h80, 32'h0, 1'b0);
    single(1'b1, 32'h02, $urandom(), 1'b0);
    single(1'b1, 32'h100, $urandom(), 1'b0);
    single(1'b0, 32'h08, 32'h0, 1'b1);

    reset_mid_write(32'hA1B2C3D4);
    single(1'b0, 32'h10, 32'h0, 1'b0);

    for (int k = 0; k < 80; k++) begin
      int unsigned op = $urandom_range(0, 2);
      if (op == 2) tie(rand_addr(), rand_addr(), $urandom());
      else single(op[0], rand_addr(), $urandom(), $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'h0);
    for (int i = 0; i < DEPTH; i++) chk("final_mem", {24'h0, mem[i]}, {24'h0, refmem[i]});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/imem_arbiter_ctrl.md
IMEM_ARBITER_CTRL -- requirements
Module: imem_arbiter_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning instruction memory size in bytes.
REQ-002 SHALL have parameter AW, default 7, meaning memory byte-address width (2^AW >= DEPTH).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 fetch_req  in  1  CPU fetch request, level, held until fetch_valid.
REQ-006 fetch_addr  in  32  fetch byte address, sampled at acceptance.
REQ-007 fetch_valid  out  1  one-cycle pulse: fetch response present.
REQ-008 fetch_instr  out  32  assembled instruction word.
REQ-009 fetch_err  out  1  qualifies fetch_valid: misaligned or out-of-range address.
REQ-010 load_req  in  1  program-loader write request, level, held until load_ack.
REQ-011 load_addr  in  32  loader byte address, sampled at acceptance.
REQ-012 load_data  in  32  loader word, sampled at acceptance.
REQ-013 load_ack  out  1  one-cycle pulse: write complete.
REQ-014 load_err  out  1  qualifies load_ack: misaligned or out-of-range address.
REQ-015 mem_addr  out  AW  byte address to the byte-wide memory array.
REQ-016 mem_we  out  1  byte write enable.
REQ-017 mem_wdata  out  8  byte write data.
REQ-018 mem_rdata  in  8  byte read data, combinational from mem_addr.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement states IDLE, RD, WR, RESP; a 2-bit beat counter indexes bytes 0..3.
REQ-021 Byte order SHALL be big-endian: byte at base+0 maps to word bits [31:24], base+3 to [7:0].
REQ-022 Requests SHALL be sampled only in IDLE; at acceptance the edge latches address (and data for loads) and leaves IDLE.
REQ-023 If only one requester is active in IDLE, it SHALL be granted.
REQ-024 If both are active in IDLE, grant SHALL go to the requester not granted last (round-robin); last_grant resets to fetch, so the first tie goes to the loader.
REQ-025 An address is in error when addr[1:0] != 0 or addr > DEPTH-4; an erroneous request SHALL go IDLE->RESP directly with no memory access, and mem_we stays low.
REQ-026 RD: mem_addr = base+beat, mem_we=0; mem_rdata is captured into the byte lane at each edge; after beat 3 -> RESP.
REQ-027 WR: mem_addr = base+beat, mem_we=1, mem_wdata = latched byte for beat; after beat 3 -> RESP.
REQ-028 RESP SHALL last one cycle and assert fetch_valid or load_ack (with the matching err bit), then go to IDLE.
REQ-029 Latency from the accepting edge SHALL be 5 cycles for a valid request and 1 cycle for an error request.
REQ-030 On error, fetch_instr SHALL be 0; otherwise fetch_instr SHALL hold its last value until the next fetch response.
REQ-031 A requester SHALL deassert req in the response cycle; a req still high in the following IDLE cycle is a new request.
REQ-032 Deassertion of req mid-transaction SHALL NOT abort it; the response still pulses.
REQ-033 mem_we SHALL never be high outside WR; mem_addr SHALL be 0 in IDLE.

Reset
REQ-034 rst_n low SHALL immediately force IDLE, beat=0, last_grant=fetch, and all outputs to 0 (fetch_instr=0, mem_we=0), including mid-transaction.
REQ-035 A write interrupted by reset SHALL leave earlier beats written and later beats unwritten; no ack is issued.

Verification
REQ-036 Load addr 0x0, data 0x20100000; fetch 0x0 -> load_ack 5 cycles after accept; fetch_valid 5 cycles later with instr 0x20100000, err=0.
REQ-037 Load 0x08 with data 0x12345678 -> memory bytes 8..11 = 0x12, 0x34, 0x56, 0x78 exactly.
REQ-038 fetch_req and load_req asserted together from reset -> load served first, fetch next; repeat the tie -> order alternates.
REQ-039 Fetch 0x06 -> next-cycle fetch_valid=1, err=1, instr=0, no mem_addr activity; fetch 0x7C -> valid, err=0; fetch 0x80 -> err=1.
REQ-040 Assert rst_n low during WR beat 2 of load to 0x10 -> bytes 0x10 and 0x11 written, 0x12 and 0x13 unchanged, no load_ack, busy=0.
REQ-041 Drop fetch_req one cycle after acceptance -> fetch_valid still pulses at cycle 5 with correct data.
